// File: rtl/muldiv_divider_pool.sv
// muldiv_divider_pool: pool of lowest-free-allocated iterative restoring dividers with selective flush.
// Define MULDIV_DIV_EARLY_OUT_EN to finish in one iteration when |dividend| < |divisor|.
module muldiv_divider_pool #(
    parameter int NUM_DIV        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int AL_INDEX_WIDTH = 6,
    parameter int RADIX_BITS     = 1,
    localparam int SW            = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1,
    localparam int FW            = $clog2(NUM_DIV) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acquire_valid,
    input  logic [AL_INDEX_WIDTH-1:0]     acquire_al_ptr,
    output logic                          acquire_grant,
    output logic [SW-1:0]                 acquire_slot,
    input  logic                          req_valid,
    input  logic [SW-1:0]                 req_slot,
    input  logic [DATA_WIDTH-1:0]         op_a,
    input  logic [DATA_WIDTH-1:0]         op_b,
    input  logic [1:0]                    div_code,
    input  logic                          release_valid,
    input  logic [SW-1:0]                 release_slot,
    input  logic                          flush_valid,
    input  logic                          flush_all,
    input  logic [AL_INDEX_WIDTH-1:0]     flush_head,
    input  logic [AL_INDEX_WIDTH-1:0]     flush_tail,
    output logic [NUM_DIV-1:0]            result_valid,
    output logic [NUM_DIV*DATA_WIDTH-1:0] result_data,
    output logic [NUM_DIV-1:0]            busy_mask,
    output logic [FW-1:0]                 free_count
);
    localparam int ITER = DATA_WIDTH / RADIX_BITS;
    localparam int CW   = $clog2(ITER + 1);
    typedef enum logic [1:0] {FREE, RESERVED, PROCESSING, WAITING} phase_e;
    phase_e                    phase_q [NUM_DIV];
    phase_e                    phase_d [NUM_DIV];
    logic [AL_INDEX_WIDTH-1:0] ptr_q   [NUM_DIV];
    logic [AL_INDEX_WIDTH-1:0] ptr_d   [NUM_DIV];
    logic [CW-1:0]             cnt_q   [NUM_DIV];
    logic [CW-1:0]             cnt_d   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     quo_q   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     quo_d   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     rem_q   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     rem_d   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     dvs_q   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     dvs_d   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     res_q   [NUM_DIV];
    logic [DATA_WIDTH-1:0]     res_d   [NUM_DIV];
    logic [1:0]                code_q  [NUM_DIV];
    logic [1:0]                code_d  [NUM_DIV];
    logic [NUM_DIV-1:0]        raw_q, raw_d, negq_q, negq_d, negr_q, negr_d;
    logic                      sgn, a_neg, b_neg, zero, ovf, early, raw, in_rng, hit;
    logic [DATA_WIDTH-1:0]     abs_a, abs_b, raw_quo, raw_rem;
    logic [DATA_WIDTH:0]       t;
    assign sgn     = ~div_code[0];
    assign a_neg   = sgn & op_a[DATA_WIDTH-1];
    assign b_neg   = sgn & op_b[DATA_WIDTH-1];
    assign abs_a   = a_neg ? -op_a : op_a;
    assign abs_b   = b_neg ? -op_b : op_b;
    assign zero    = op_b == '0;
    assign ovf     = sgn && op_a == {1'b1, {(DATA_WIDTH-1){1'b0}}} && op_b == '1;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    assign early   = ~zero & (abs_a < abs_b);
`else
    assign early   = 1'b0;
`endif
    // Special cases skip iteration: results are final at request time and bypass sign fix-up.
    assign raw     = zero | ovf | early;
    assign raw_quo = zero ? '1 : ovf ? op_a : '0;
    assign raw_rem = ovf ? '0 : op_a;
    always_comb begin
        acquire_slot = '0;
        free_count   = '0;
        for (int i = NUM_DIV - 1; i >= 0; i--) begin
            if (phase_q[i] == FREE) acquire_slot = SW'(i);
            free_count = free_count + FW'(phase_q[i] == FREE);
        end
        acquire_grant = acquire_valid & ~flush_valid & (free_count != '0);
    end
    always_comb begin
        result_valid = '0;
        busy_mask    = '0;
        result_data  = '0;
        for (int i = 0; i < NUM_DIV; i++) begin
            result_valid[i] = phase_q[i] == WAITING;
            busy_mask[i]    = phase_q[i] == PROCESSING;
            result_data[i*DATA_WIDTH +: DATA_WIDTH] = res_q[i];
        end
    end
    always_comb begin
        t      = '0;
        in_rng = 1'b0;
        hit    = 1'b0;
        raw_d  = raw_q;
        negq_d = negq_q;
        negr_d = negr_q;
        for (int i = 0; i < NUM_DIV; i++) begin
            phase_d[i] = phase_q[i];
            ptr_d[i]   = ptr_q[i];
            cnt_d[i]   = cnt_q[i];
            quo_d[i]   = quo_q[i];
            rem_d[i]   = rem_q[i];
            dvs_d[i]   = dvs_q[i];
            res_d[i]   = res_q[i];
            code_d[i]  = code_q[i];
            in_rng = (flush_head < flush_tail) ? (ptr_q[i] >= flush_head && ptr_q[i] < flush_tail) :
                     (flush_head > flush_tail) ? (ptr_q[i] >= flush_head || ptr_q[i] < flush_tail) : 1'b0;
            hit = phase_q[i] != FREE && (flush_all || in_rng);
            if (flush_valid && hit) begin
                phase_d[i] = FREE;
                cnt_d[i]   = '0;
            end else if (release_valid && release_slot == SW'(i) && phase_q[i] == WAITING) begin
                phase_d[i] = FREE;
            end else if (req_valid && req_slot == SW'(i) && phase_q[i] == RESERVED) begin
                phase_d[i] = PROCESSING;
                cnt_d[i]   = raw ? CW'(1) : CW'(ITER);
                quo_d[i]   = raw ? raw_quo : abs_a;
                rem_d[i]   = raw ? raw_rem : '0;
                dvs_d[i]   = abs_b;
                code_d[i]  = div_code;
                raw_d[i]   = raw;
                negq_d[i]  = a_neg ^ b_neg;
                negr_d[i]  = a_neg;
            end else if (phase_q[i] == PROCESSING) begin
                if (cnt_q[i] == '0) begin
                    phase_d[i] = WAITING;
                    res_d[i]   = raw_q[i] ? (code_q[i][1] ? rem_q[i] : quo_q[i]) :
                                 code_q[i][1] ? (negr_q[i] ? -rem_q[i] : rem_q[i]) :
                                 (negq_q[i] ? -quo_q[i] : quo_q[i]);
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                    if (!raw_q[i]) begin
                        for (int k = 0; k < RADIX_BITS; k++) begin
                            t        = {rem_d[i], quo_d[i][DATA_WIDTH-1]};
                            quo_d[i] = {quo_d[i][DATA_WIDTH-2:0], 1'b0};
                            if (t >= {1'b0, dvs_q[i]}) begin
                                t           = t - {1'b0, dvs_q[i]};
                                quo_d[i][0] = 1'b1;
                            end
                            rem_d[i] = t[DATA_WIDTH-1:0];
                        end
                    end
                end
            end else if (acquire_grant && acquire_slot == SW'(i)) begin
                phase_d[i] = RESERVED;
                ptr_d[i]   = acquire_al_ptr;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIV; i++) begin
                phase_q[i] <= FREE;
                ptr_q[i]   <= '0;
                cnt_q[i]   <= '0;
                quo_q[i]   <= '0;
                rem_q[i]   <= '0;
                dvs_q[i]   <= '0;
                res_q[i]   <= '0;
                code_q[i]  <= '0;
            end
            raw_q  <= '0;
            negq_q <= '0;
            negr_q <= '0;
        end else begin
            phase_q <= phase_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            code_q  <= code_d;
            raw_q   <= raw_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end
endmodule

// File: tb/tb_muldiv_divider_pool.sv
// tb_muldiv_divider_pool: vector table, corner sequences and random paired ops against an arithmetic model.
module tb_muldiv_divider_pool;
    logic        clk, rst;
    logic        acquire_valid, acquire_grant, acquire_slot;
    logic [5:0]  acquire_al_ptr, flush_head, flush_tail;
    logic        req_valid, req_slot, release_valid, release_slot, flush_valid, flush_all;
    logic [31:0] op_a, op_b;
    logic [1:0]  div_code;
    logic [1:0]  result_valid, busy_mask, free_count;
    logic [63:0] result_data;
    int errors = 0;
    int checks = 0;
    localparam int EL =
`ifdef MULDIV_DIV_EARLY_OUT_EN
        2;
`else
        33;
`endif
    muldiv_divider_pool #(.NUM_DIV(2), .DATA_WIDTH(32), .AL_INDEX_WIDTH(6), .RADIX_BITS(1)) dut (
        .clk(clk), .rst(rst),
        .acquire_valid(acquire_valid), .acquire_al_ptr(acquire_al_ptr),
        .acquire_grant(acquire_grant), .acquire_slot(acquire_slot),
        .req_valid(req_valid), .req_slot(req_slot), .op_a(op_a), .op_b(op_b), .div_code(div_code),
        .release_valid(release_valid), .release_slot(release_slot),
        .flush_valid(flush_valid), .flush_all(flush_all), .flush_head(flush_head), .flush_tail(flush_tail),
        .result_valid(result_valid), .result_data(result_data), .busy_mask(busy_mask), .free_count(free_count)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    typedef struct {
        logic [1:0]  code;
        logic [31:0] a, b, res;
        int          lat;
    } vec_t;
    vec_t tbl[16];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] ref_res(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        if (b == 0) return c[1] ? a : 32'hFFFFFFFF;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (!c[0]) return 32'(c[1] ? sa % sb : sa / sb);
        return 32'(c[1] ? ua % ub : ua / ub);
    endfunction
    function automatic int ref_lat(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EARLY_OUT_EN
        longint ma, mb;
`endif
        if (b == 0) return 2;
        if (!c[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
`ifdef MULDIV_DIV_EARLY_OUT_EN
        ma = c[0] ? longint'(a) : longint'($signed(a));
        mb = c[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (ma < mb) return 2;
`endif
        return 33;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_acquire(input logic [5:0] p, input logic exp_grant, input logic exp_slot, input string nm);
        acquire_valid  = 1;
        acquire_al_ptr = p;
        #1;
        chk({nm, "_grant"}, 64'(acquire_grant), 64'(exp_grant));
        if (acquire_grant) chk({nm, "_slot"}, 64'(acquire_slot), 64'(exp_slot));
        step();
        acquire_valid = 0;
    endtask
    task automatic do_req(input logic s, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1;
        req_slot  = s;
        div_code  = c;
        op_a      = a;
        op_b      = b;
        step();
        req_valid = 0;
    endtask
    task automatic do_release(input logic s);
        release_valid = 1;
        release_slot  = s;
        step();
        release_valid = 0;
    endtask
    task automatic run_one(input string nm, input vec_t v);
        int first;
        first = -1;
        do_acquire(6'($urandom), 1, 0, nm);
        do_req(0, v.code, v.a, v.b);
        chk({nm, "_busy"}, 64'(busy_mask), 64'(2'b01));
        for (int n = 1; n <= 60 && first < 0; n++) begin
            step();
            if (result_valid[0]) first = n;
        end
        chk({nm, "_lat"}, 64'(first), 64'(v.lat));
        chk({nm, "_res"}, 64'(result_data[31:0]), 64'(v.res));
        do_release(0);
        chk({nm, "_free"}, 64'(free_count), 64'(2));
    endtask
    task automatic run_pair(input logic [1:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                            input logic [1:0] c1, input logic [31:0] a1, input logic [31:0] b1);
        int f0, f1;
        f0 = -1;
        f1 = -1;
        do_acquire(6'($urandom), 1, 0, "pair_acq0");
        do_acquire(6'($urandom), 1, 1, "pair_acq1");
        do_req(0, c0, a0, b0);
        do_req(1, c1, a1, b1);
        for (int n = 1; n <= 80 && (f0 < 0 || f1 < 0); n++) begin
            step();
            if (f0 < 0 && result_valid[0]) f0 = n;
            if (f1 < 0 && result_valid[1]) f1 = n;
        end
        chk("pair_lat0", 64'(f0), 64'(ref_lat(c0, a0, b0) - 1));
        chk("pair_lat1", 64'(f1), 64'(ref_lat(c1, a1, b1)));
        chk("pair_res0", 64'(result_data[31:0]), 64'(ref_res(c0, a0, b0)));
        chk("pair_res1", 64'(result_data[63:32]), 64'(ref_res(c1, a1, b1)));
        release_valid = 1;
        release_slot  = 0;
        acquire_valid = 1;
        #1;
        chk("pair_nogrant_same_cycle", 64'(acquire_grant), 64'(0));
        step();
        release_valid = 0;
        acquire_valid = 0;
        chk("pair_free_after_rel0", 64'(free_count), 64'(1));
        do_release(1);
    endtask
    function automatic logic [31:0] rnd_b();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'($urandom_range(1, 20));
            3:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction
    function automatic logic [31:0] rnd_a();
        case ($urandom_range(0, 3))
            0:       return 32'h80000000;
            1:       return 32'($urandom_range(0, 30));
            2:       return -32'($urandom_range(0, 30));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        tbl[0]  = '{2'd1, 32'd100,        32'd7,        32'd14,         33};
        tbl[1]  = '{2'd3, 32'd100,        32'd7,        32'd2,          33};
        tbl[2]  = '{2'd0, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   33};
        tbl[3]  = '{2'd2, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,   33};
        tbl[4]  = '{2'd0, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   33};
        tbl[5]  = '{2'd2, 32'd7,          32'hFFFFFFFE, 32'd1,          33};
        tbl[6]  = '{2'd0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   2};
        tbl[7]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF, 32'd0,          2};
        tbl[8]  = '{2'd1, 32'd5,          32'd0,        32'hFFFFFFFF,   2};
        tbl[9]  = '{2'd3, 32'd5,          32'd0,        32'd5,          2};
        tbl[10] = '{2'd0, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF,   2};
        tbl[11] = '{2'd2, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB,   2};
        tbl[12] = '{2'd1, 32'd3,          32'd10,       32'd0,          EL};
        tbl[13] = '{2'd3, 32'd3,          32'd10,       32'd3,          EL};
        tbl[14] = '{2'd2, 32'hFFFFFFFD,   32'd10,       32'hFFFFFFFD,   EL};
        tbl[15] = '{2'd1, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   33};
        rst = 0;
        acquire_valid = 0; acquire_al_ptr = 0; req_valid = 0; req_slot = 0;
        op_a = 0; op_b = 0; div_code = 0; release_valid = 0; release_slot = 0;
        flush_valid = 0; flush_all = 0; flush_head = 0; flush_tail = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_free", 64'(free_count), 64'(2));
        chk("rst_busy", 64'(busy_mask), 64'(0));
        chk("rst_valid", 64'(result_valid), 64'(0));
        chk("rst_data", result_data, 64'(0));
        chk("rst_grant", 64'(acquire_grant), 64'(0));
        rst = 1;
        step();
        for (int i = 0; i < 16; i++) run_one($sformatf("vec%0d", i), tbl[i]);
        chk("acq3_free0", 64'(free_count), 64'(2));
        do_acquire(6'd1, 1, 0, "acq3_a");
        chk("acq3_free1", 64'(free_count), 64'(1));
        do_acquire(6'd2, 1, 1, "acq3_b");
        chk("acq3_free2", 64'(free_count), 64'(0));
        do_acquire(6'd3, 0, 0, "acq3_c");
        flush_valid = 1; flush_all = 1;
        step();
        flush_valid = 0; flush_all = 0;
        chk("flushall_free", 64'(free_count), 64'(2));
        do_acquire(6'd62, 1, 0, "rng_a");
        do_acquire(6'd3, 1, 1, "rng_b");
        do_req(0, 2'd1, 32'd100, 32'd7);
        do_req(1, 2'd1, 32'd100, 32'd7);
        step();
        flush_valid = 1; flush_head = 6'd60; flush_tail = 6'd2;
        step();
        flush_valid = 0;
        chk("rng_busy", 64'(busy_mask), 64'(2'b10));
        chk("rng_free", 64'(free_count), 64'(1));
        begin
            int got;
            bit leak;
            got = -1;
            leak = 0;
            for (int n = 1; n <= 40 && got < 0; n++) begin
                step();
                if (result_valid[0]) leak = 1;
                if (result_valid[1]) got = n;
            end
            chk("rng_slot1_done", 64'(got > 0), 64'(1));
            chk("rng_slot0_quiet", 64'(leak), 64'(0));
            chk("rng_res1", 64'(result_data[63:32]), 64'(14));
        end
        do_release(1);
        chk("rng_free_end", 64'(free_count), 64'(2));
        do_acquire(6'd10, 1, 0, "relfl_acq");
        do_req(0, 2'd1, 32'd5, 32'd0);
        step();
        step();
        chk("relfl_wait", 64'(result_valid), 64'(2'b01));
        release_valid = 1; release_slot = 0; flush_valid = 1; flush_all = 1;
        step();
        release_valid = 0; flush_valid = 0; flush_all = 0;
        chk("relfl_free", 64'(free_count), 64'(2));
        chk("relfl_valid", 64'(result_valid), 64'(0));
        do_acquire(6'd20, 1, 0, "reqfl_acq");
        req_valid = 1; req_slot = 0; div_code = 2'd1; op_a = 32'd9; op_b = 32'd0;
        flush_valid = 1; flush_all = 1;
        step();
        req_valid = 0; flush_valid = 0; flush_all = 0;
        chk("reqfl_busy", 64'(busy_mask), 64'(0));
        chk("reqfl_free", 64'(free_count), 64'(2));
        repeat (3) step();
        chk("reqfl_valid", 64'(result_valid), 64'(0));
        do_req(1, 2'd1, 32'd9, 32'd3);
        chk("reqfree_busy", 64'(busy_mask), 64'(0));
        chk("reqfree_free", 64'(free_count), 64'(2));
        for (int i = 0; i < 30; i++)
            run_pair(2'($urandom), rnd_a(), rnd_b(), 2'($urandom), rnd_a(), rnd_b());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
